// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_buf.sv
// Synchronous byte FIFO; head is visible combinationally, full/empty derive from the count.
module uart_tx_fifo_buf
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                push,
  input  logic                                pop,
  input  logic [UART_DATA_W-1:0]              wdata,
  output logic [UART_DATA_W-1:0]              rdata,
  output logic                                full,
  output logic                                empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     level
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);

  logic [UART_DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wptr;
  logic [PTR_W-1:0]       rptr;
  logic                   do_push;
  logic                   do_pop;

  assign full    = (level == LVL_W'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // Pointers wrap naturally; the count disambiguates full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1 / 8E1, LSB first) fed from a small byte FIFO.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            tx_en,
  input  logic [UART_DATA_W-1:0]          in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic                            tx,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

  localparam int unsigned CPB    = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned BAUD_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int unsigned BIT_W  = $clog2(UART_DATA_W);

  if (CPB < 2) begin : g_cpb_chk
    $error("uart_tx_fifo: CLKS_PER_BIT must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2 and at least 2");
  end

  uart_tx_state_e         state_q, state_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [UART_DATA_W-1:0] shreg_q, shreg_d;
  logic                   par_q, par_d;
  logic                   tx_d;
  logic                   busy_d;
  logic                   pop_c;
  logic [UART_DATA_W-1:0] head;
  logic                   full;
  logic                   empty;
  logic                   bit_end;
  logic                   can_start;

  uart_tx_fifo_buf #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (pop_c),
    .wdata (in_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign in_ready  = !full;
  assign bit_end   = (baud_q == BAUD_W'(CPB - 1));
  assign can_start = !empty && tx_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx      <= tx_d;
      busy    <= busy_d;
    end
  end

  // Next-state and line value; tx_d is the value the line carries for the coming bit period.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx;
    busy_d  = busy;
    pop_c   = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (can_start) begin
          state_d = START;
          pop_c   = 1'b1;
          shreg_d = head;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          baud_d  = '0;
          par_d   = 1'b0;
        end
      end

      START: begin
        if (bit_end) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shreg_q[0];
          par_d   = par_q ^ shreg_q[0];
          shreg_d = shreg_q >> 1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == BIT_W'(UART_DATA_W - 1)) begin
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            tx_d    = shreg_q[0];
            par_d   = par_q ^ shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          baud_d  = '0;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          // Chain straight into the next start bit so consecutive frames have no idle gap.
          if (can_start) begin
            state_d = START;
            pop_c   = 1'b1;
            shreg_d = head;
            tx_d    = 1'b0;
            par_d   = 1'b0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: one instance without parity, one with even parity.
module tb_uart_tx_fifo;

  localparam int unsigned CLK_FREQ  = 1000000;
  localparam int unsigned BAUD_RATE = 100000;
  localparam int unsigned DEPTH     = 8;
  localparam int unsigned CPB       = CLK_FREQ / BAUD_RATE;
  localparam int unsigned LVL_W     = $clog2(DEPTH + 1);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_en = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned NBITS = 10 + g;

    logic             in_ready;
    logic             tx;
    logic             busy;
    logic [LVL_W-1:0] fifo_level;

    uart_tx_fifo #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BAUD_RATE),
      .PARITY_EN (g),
      .FIFO_DEPTH(DEPTH)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .tx_en     (tx_en),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .tx        (tx),
      .busy      (busy),
      .fifo_level(fifo_level)
    );

    // Reference model: bytes accepted but not yet on the line, in order.
    byte unsigned exp_q[$];
    int           mcnt     = 0;
    bit           in_frame = 1'b0;
    int           phase    = 0;
    int           k        = 0;
    logic         tx_prev  = 1'b1;
    logic [7:0]   cur      = 8'h00;
    logic [7:0]   got      = 8'h00;
    int           run      = 0;
    int           last_run = 0;

    always @(posedge clk) begin
      if (rst) begin
        exp_q.delete();
        mcnt = 0;
      end else if (in_valid && (mcnt < DEPTH)) begin
        exp_q.push_back(in_data);
        mcnt++;
      end
    end

    // Line decoder: samples each bit mid-period and scores the frame against the model.
    always @(negedge clk) begin
      if (rst) begin
        in_frame = 1'b0;
        tx_prev  = 1'b1;
        run      = 0;
      end else begin
        if (!in_frame && tx_prev && !tx) begin
          chk($sformatf("p%0d start_has_queued_byte", g), 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            in_frame = 1'b1;
            phase    = 0;
            got      = 8'h00;
            cur      = exp_q.pop_front();
            mcnt--;
          end
        end else if (in_frame) begin
          phase++;
        end

        if (in_frame && ((phase % CPB) == (CPB / 2 - 1))) begin
          k = phase / CPB;
          if (k == 0) begin
            chk($sformatf("p%0d start_bit", g), 32'(tx), 32'd0);
          end else if (k <= 8) begin
            got[3'(k - 1)] = tx;
            if (k == 8) chk($sformatf("p%0d data_byte", g), 32'(got), 32'(cur));
          end else if (k == NBITS - 1) begin
            chk($sformatf("p%0d stop_bit", g), 32'(tx), 32'd1);
            in_frame = 1'b0;
          end else begin
            chk($sformatf("p%0d parity_bit", g), 32'(tx), 32'(^cur));
          end
        end

        chk($sformatf("p%0d fifo_level", g), 32'(fifo_level), 32'(mcnt));
        chk($sformatf("p%0d in_ready", g), 32'(in_ready), 32'(mcnt < DEPTH));

        if (busy) begin
          run++;
        end else begin
          if (run > 0) last_run = run;
          run = 0;
        end
        tx_prev = tx;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic check_both(input string tag, input int etx, input int ebusy, input int elvl);
    chk({tag, " p0 tx"},       32'(g_dut[0].tx),         32'(etx));
    chk({tag, " p0 busy"},     32'(g_dut[0].busy),       32'(ebusy));
    chk({tag, " p0 level"},    32'(g_dut[0].fifo_level), 32'(elvl));
    chk({tag, " p0 in_ready"}, 32'(g_dut[0].in_ready),   32'(elvl < DEPTH));
    chk({tag, " p1 tx"},       32'(g_dut[1].tx),         32'(etx));
    chk({tag, " p1 busy"},     32'(g_dut[1].busy),       32'(ebusy));
    chk({tag, " p1 level"},    32'(g_dut[1].fifo_level), 32'(elvl));
    chk({tag, " p1 in_ready"}, 32'(g_dut[1].in_ready),   32'(elvl < DEPTH));
  endtask

  function automatic bit all_idle();
    return !g_dut[0].busy && !g_dut[1].busy && !g_dut[0].in_frame && !g_dut[1].in_frame &&
           (g_dut[0].exp_q.size() == 0) && (g_dut[1].exp_q.size() == 0);
  endfunction

  task automatic wait_idle(input string tag, input int bound);
    int i = 0;
    while ((i < bound) && !all_idle()) begin
      tick(1);
      i++;
    end
    chk({tag, " drain_within_bound"}, 32'(all_idle()), 32'd1);
    tick(2);
  endtask

  task automatic wait_not_busy(input string tag, input int bound);
    int i = 0;
    while ((i < bound) && (g_dut[0].busy || g_dut[1].busy)) begin
      tick(1);
      i++;
    end
    chk({tag, " frame_end_within_bound"}, 32'(g_dut[0].busy || g_dut[1].busy), 32'd0);
  endtask

  task automatic clear_runs();
    g_dut[0].last_run = 0;
    g_dut[1].last_run = 0;
  endtask

  initial begin
    rst = 1'b1;
    tick(3);
    check_both("reset", 1, 0, 0);
    rst = 1'b0;
    tick(2);

    // Single byte: latency and frame length
    clear_runs();
    push(8'h41);
    check_both("single_after_push", 1, 0, 1);
    tick(1);
    check_both("single_first_start", 0, 1, 0);
    wait_idle("single", 3000);
    chk("single p0 busy_cycles", 32'(g_dut[0].last_run), 32'(10 * CPB));
    chk("single p1 busy_cycles", 32'(g_dut[1].last_run), 32'(11 * CPB));

    // Parity cases
    clear_runs();
    push(8'h07);
    wait_idle("parity07", 3000);
    chk("parity07 p1 busy_cycles", 32'(g_dut[1].last_run), 32'(11 * CPB));
    push(8'h03);
    wait_idle("parity03", 3000);

    // Back-to-back frames
    clear_runs();
    push(8'h0A);
    check_both("b2b_1", 1, 0, 1);
    push(8'h55);
    check_both("b2b_2", 0, 1, 1);
    push(8'hFF);
    check_both("b2b_3", 0, 1, 2);
    wait_idle("b2b", 5000);
    chk("b2b p0 busy_cycles", 32'(g_dut[0].last_run), 32'(3 * 10 * CPB));
    chk("b2b p1 busy_cycles", 32'(g_dut[1].last_run), 32'(3 * 11 * CPB));

    // Fill the FIFO with the transmitter held off
    tx_en = 1'b0;
    tick(1);
    for (int i = 0; i < 9; i++) begin
      push(8'($urandom));
      check_both($sformatf("fill_%0d", i), 1, 0, (i < 8) ? i + 1 : 8);
    end
    tick(20);
    check_both("fill_hold", 1, 0, 8);
    tx_en = 1'b1;
    wait_idle("fill_drain", 12000);

    // tx_en dropped mid-frame
    push(8'hC3);
    push(8'h5A);
    push(8'h81);
    tick(30);
    tx_en = 1'b0;
    wait_not_busy("txen_drop", 2000);
    tick(40);
    check_both("txen_hold", 1, 0, 2);
    tx_en = 1'b1;
    wait_idle("txen_resume", 5000);

    // Reset during data bit 3
    push(8'hB6);
    push(8'h29);
    tick(44);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_both("midframe_reset", 1, 0, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    tick(40);
    check_both("post_reset_idle", 1, 0, 0);

    // Randomized traffic with tx_en toggling
    for (int i = 0; i < 80; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      tx_en    = ($urandom_range(0, 7) != 0);
      tick(1);
    end
    in_valid = 1'b0;
    tx_en    = 1'b1;
    wait_idle("random", 20000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
